// File: rtl/wall_controller.sv
// Wall slot manager: scrolls walls left on each frame tick, spawns new
// walls at a fixed spacing, and streams the live walls to the drawer on demand.
module wall_controller #(
   parameter int SCREEN_X  = 160,
   parameter int SPACING   = 40,
   parameter int MAX_H     = 120,
   parameter int NUM_WALLS = 4
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [7:0] height_in,
   output logic       height_ack,
   input  logic       dump_req,
   output logic       wall_valid,
   input  logic       wall_ready,
   output logic [7:0] wall_x,
   output logic [7:0] wall_h,
   output logic       dump_done,
   output logic [7:0] score
);

   localparam int IW = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;

   typedef enum logic [1:0] {IDLE, SCROLL, SPAWN, DUMP} state_t;

   state_t               state, state_n;
   logic [NUM_WALLS-1:0] valid, valid_n;
   logic [7:0]           x   [NUM_WALLS];
   logic [7:0]           x_n [NUM_WALLS];
   logic [7:0]           h   [NUM_WALLS];
   logic [7:0]           h_n [NUM_WALLS];
   logic [7:0]           cnt, cnt_n;
   logic [7:0]           score_n;
   logic                 pend, pend_n;
   logic [IW-1:0]        idx, idx_n;
   logic                 free_found;
   logic [IW-1:0]        free_idx;
   logic [7:0]           h_clamp;

   assign h_clamp = (height_in > 8'(MAX_H)) ? 8'(MAX_H) : height_in;

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < NUM_WALLS; i++) begin
         if (!valid[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

   always_comb begin
      state_n    = state;
      valid_n    = valid;
      x_n        = x;
      h_n        = h;
      cnt_n      = cnt;
      score_n    = score;
      pend_n     = pend;
      idx_n      = idx;
      height_ack = 1'b0;
      dump_done  = 1'b0;
      wall_valid = 1'b0;
      wall_x     = 8'd0;
      wall_h     = 8'd0;
      // Ticks that land while busy are remembered, at most one deep
      if (tick && state != IDLE) pend_n = 1'b1;
      unique case (state)
         IDLE: begin
            if (tick || pend) begin
               state_n = SCROLL;
               pend_n  = 1'b0;
            end else if (dump_req) begin
               state_n = DUMP;
               idx_n   = '0;
            end
         end
         SCROLL: begin
            for (int i = 0; i < NUM_WALLS; i++) begin
               if (valid[i]) begin
                  if (x[i] == 8'd0) begin
                     valid_n[i] = 1'b0;
                     if (score_n != 8'hFF) score_n = score_n + 8'd1;
                  end else begin
                     x_n[i] = x[i] - 8'd1;
                  end
               end
            end
            cnt_n   = cnt + 8'd1;
            state_n = (cnt == 8'(SPACING - 1)) ? SPAWN : IDLE;
         end
         SPAWN: begin
            if (free_found) begin
               valid_n[free_idx] = 1'b1;
               x_n[free_idx]     = 8'(SCREEN_X - 1);
               h_n[free_idx]     = h_clamp;
               height_ack        = !reset;
            end
            cnt_n   = 8'd0;
            state_n = IDLE;
         end
         DUMP: begin
            wall_valid = valid[idx];
            if (valid[idx]) begin
               wall_x = x[idx];
               wall_h = h[idx];
            end
            if (!valid[idx] || wall_ready) begin
               if (idx == IW'(NUM_WALLS - 1)) begin
                  dump_done = !reset;
                  state_n   = IDLE;
               end else begin
                  idx_n = idx + IW'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         valid <= '0;
         cnt   <= 8'd0;
         score <= 8'd0;
         pend  <= 1'b0;
         idx   <= '0;
      end else begin
         state <= state_n;
         valid <= valid_n;
         cnt   <= cnt_n;
         score <= score_n;
         pend  <= pend_n;
         idx   <= idx_n;
         x     <= x_n;
         h     <= h_n;
      end
   end

endmodule

// File: tb/tb_wall_controller.sv
// Directed-plus-random bench for wall_controller against a list-of-walls
// reference model driven by frame ticks.
module tb_wall_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic [7:0] height_in;
   logic       height_ack;
   logic       dump_req;
   logic       wall_valid;
   logic       wall_ready;
   logic [7:0] wall_x;
   logic [7:0] wall_h;
   logic       dump_done;
   logic [7:0] score;

   wall_controller dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .height_in  (height_in),
      .height_ack (height_ack),
      .dump_req   (dump_req),
      .wall_valid (wall_valid),
      .wall_ready (wall_ready),
      .wall_x     (wall_x),
      .wall_h     (wall_h),
      .dump_done  (dump_done),
      .score      (score)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int ack_total  = 0;
   int exp_acks   = 0;

   // reference model: walls as (live, x, h) records
   bit mv [4];
   int mx [4];
   int mh [4];
   int mscore;
   int mticks;

   logic       s_ack, s_valid, s_done;
   logic [7:0] s_x, s_h;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < 4; i++) mv[i] = 0;
      mscore = 0;
      mticks = 0;
   endtask

   // one frame: walls at the left edge leave, the rest move left;
   // every 40th frame a new wall appears at the right edge
   task automatic mdl_tick(input int hin);
      for (int i = 0; i < 4; i++) begin
         if (mv[i]) begin
            if (mx[i] == 0) begin
               mv[i] = 0;
               mscore = (mscore < 255) ? mscore + 1 : 255;
            end else begin
               mx[i] = mx[i] - 1;
            end
         end
      end
      mticks++;
      if (mticks % 40 == 0) begin
         for (int i = 0; i < 4; i++) begin
            if (!mv[i]) begin
               mv[i] = 1;
               mx[i] = 159;
               mh[i] = (hin > 120) ? 120 : hin;
               exp_acks++;
               break;
            end
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      s_ack   = height_ack;
      s_valid = wall_valid;
      s_done  = dump_done;
      s_x     = wall_x;
      s_h     = wall_h;
      if (height_ack === 1'b1) ack_total++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick(input int hin);
      height_in = 8'(hin);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat (3) cyc();
      mdl_tick(hin);
      check("ack_count", ack_total, exp_acks);
      check("score", score, mscore);
   endtask

   task automatic do_dump(input bit stall5, input bit tick_mid);
      int exp_q[$];
      int got_q[$];
      int stall_left;
      int cycles;
      bit done;
      bit held;
      logic [7:0] hx, hh;
      for (int i = 0; i < 4; i++)
         if (mv[i]) exp_q.push_back(mx[i] * 256 + mh[i]);
      stall_left = stall5 ? 5 : 0;
      cycles = 0;
      done = 0;
      held = 0;
      hx = 8'd0;
      hh = 8'd0;
      dump_req = 1'b1;
      while (!done && cycles < 200) begin
         wall_ready = (stall_left > 0) ? 1'b0 : 1'($urandom_range(0, 1));
         tick = tick_mid && cycles == 2;
         cyc();
         tick = 1'b0;
         if (held) begin
            check("stall_valid", s_valid, 1'b1);
            check("stall_x", s_x, hx);
            check("stall_h", s_h, hh);
         end
         held = 0;
         if (s_valid === 1'b1) begin
            if (wall_ready) begin
               got_q.push_back(s_x * 256 + s_h);
            end else begin
               held = 1;
               hx = s_x;
               hh = s_h;
               if (stall_left > 0) stall_left--;
            end
         end
         if (s_done === 1'b1) done = 1;
         cycles++;
      end
      dump_req = 1'b0;
      wall_ready = 1'b0;
      check("dump_done_seen", done, 1'b1);
      check("beat_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check("beat_xh", got_q[i], exp_q[i]);
   endtask

   initial begin
      reset = 1'b1;
      tick = 1'b0;
      height_in = 8'd0;
      dump_req = 1'b0;
      wall_ready = 1'b0;
      mdl_reset();
      repeat (2) cyc();
      check("rst_ack", s_ack, 1'b0);
      check("rst_valid", s_valid, 1'b0);
      check("rst_done", s_done, 1'b0);
      check("rst_x", s_x, 8'd0);
      check("rst_h", s_h, 8'd0);
      reset = 1'b0;
      cyc();
      check("rst_score", score, 8'd0);

      // empty dump: only dump_done
      do_dump(1'b0, 1'b0);

      // first spawn after the 40th tick
      for (int i = 0; i < 40; i++) do_tick(50);
      check("first_ack", ack_total, 1);
      do_dump(1'b0, 1'b0);

      // tall wall is clamped
      for (int i = 0; i < 40; i++) do_tick(200);
      do_dump(1'b0, 1'b0);

      // stalled dump with a tick landing mid-dump, then a dump that must
      // see the tick served first
      height_in = 8'd77;
      do_dump(1'b1, 1'b1);
      mdl_tick(77);
      do_dump(1'b0, 1'b0);
      check("pending_ack", ack_total, exp_acks);
      check("pending_score", score, mscore);

      // long random run with occasional dumps
      for (int i = 0; i < 1000; i++) begin
         do_tick(int'($urandom_range(0, 255)));
         if ($urandom_range(0, 60) == 0) do_dump(1'b0, 1'b0);
      end
      do_dump(1'b0, 1'b0);

      // reset landing in the spawn cycle
      while (mticks % 40 != 39) do_tick(90);
      height_in = 8'd90;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      mdl_reset();
      cyc();
      check("spawn_rst_ack", ack_total, exp_acks);
      check("spawn_rst_score", score, 8'd0);
      do_dump(1'b0, 1'b0);

      // reset landing mid-dump
      for (int i = 0; i < 40; i++) do_tick(60);
      dump_req = 1'b1;
      wall_ready = 1'b0;
      cyc();
      cyc();
      check("pre_rst_valid", s_valid, 1'b1);
      reset = 1'b1;
      dump_req = 1'b0;
      cyc();
      reset = 1'b0;
      mdl_reset();
      cyc();
      check("dump_rst_valid", s_valid, 1'b0);
      check("dump_rst_done", s_done, 1'b0);
      check("dump_rst_score", score, 8'd0);
      do_dump(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/wall_controller.md
WALL_CONTROLLER -- requirements
Module: wall_controller

Interface
REQ-001 SHALL have parameter SCREEN_X, default 160, spawn x-coordinate plus one.
REQ-002 SHALL have parameter SPACING, default 40, ticks between wall spawns.
REQ-003 SHALL have parameter MAX_H, default 120, upper clamp for stored wall height.
REQ-004 SHALL have parameter NUM_WALLS, default 4, number of wall slots.
REQ-005 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port tick  input  1  one-cycle frame-advance pulse.
REQ-008 SHALL have port height_in  input  8  wall height from the wall height generator.
REQ-009 SHALL have port height_ack  output  1  one-cycle pulse when height_in is consumed.
REQ-010 SHALL have port dump_req  input  1  drawer request to stream all live walls.
REQ-011 SHALL have port wall_valid  output  1  wall_x/wall_h hold a live wall.
REQ-012 SHALL have port wall_ready  input  1  drawer accepts beat when high with wall_valid.
REQ-013 SHALL have port wall_x  output  8  x-coordinate of the presented wall.
REQ-014 SHALL have port wall_h  output  8  height of the presented wall.
REQ-015 SHALL have port dump_done  output  1  one-cycle pulse when a dump completes.
REQ-016 SHALL have port score  output  8  count of walls retired off the left edge.

Function
REQ-017 SHALL hold NUM_WALLS slots, each with a valid bit, x[7:0] and h[7:0], plus an 8-bit spawn counter.
REQ-018 SHALL implement the FSM states IDLE, SCROLL, SPAWN and DUMP.
REQ-019 IDLE SHALL go to SCROLL on tick or tick_pending; otherwise to DUMP on dump_req; tick has priority when both occur.
REQ-020 SCROLL SHALL take one cycle: each valid slot with x==0 SHALL be invalidated and score incremented (saturating at 255, one per retired wall); every other valid slot SHALL decrement x by 1.
REQ-021 SCROLL SHALL increment the spawn counter; it SHALL go to SPAWN if the counter was SPACING-1 before the increment, otherwise to IDLE.
REQ-022 SPAWN SHALL take one cycle: write the lowest-index free slot with x=SCREEN_X-1 and h=min(height_in, MAX_H), pulse height_ack, clear the spawn counter, then go to IDLE.
REQ-023 SPAWN with no free slot SHALL write nothing, SHALL NOT pulse height_ack, SHALL clear the spawn counter and go to IDLE.
REQ-024 DUMP SHALL scan slots in index order from 0, one cycle per invalid slot, and SHALL present each valid slot with wall_valid=1.
REQ-025 wall_x, wall_h and wall_valid SHALL stay stable until the beat transfers (wall_valid&wall_ready high).
REQ-026 After the last slot is scanned or transferred, DUMP SHALL pulse dump_done for one cycle and return to IDLE; a dump with zero live walls SHALL produce no beats and only dump_done.
REQ-027 A tick arriving outside IDLE SHALL set tick_pending; multiple such ticks SHALL coalesce into one; tick_pending SHALL clear on entry to SCROLL.
REQ-028 Slot contents SHALL NOT change during DUMP.
REQ-029 height_ack SHALL be high only in SPAWN; wall_valid SHALL be high only in DUMP.

Reset
REQ-030 Reset SHALL force IDLE, clear all valid bits, the spawn counter, score and tick_pending, and drive height_ack, wall_valid and dump_done to 0, wall_x and wall_h to 0.
REQ-031 Reset asserted mid-DUMP or mid-SPAWN SHALL abort the operation with no dump_done and no height_ack on the following cycle.

Verification
REQ-032 Apply reset, then 40 ticks with height_in=50 -> exactly one height_ack after the 40th tick; a dump then returns one beat x=159, h=50 and dump_done.
REQ-033 Spawn with height_in=200 -> stored h=120 (clamped).
REQ-034 Run 1000 ticks -> at most 4 live walls at any time; the wall at x=0 retires on the next SCROLL; score increments once per retired wall.
REQ-035 Hold wall_ready low for 5 cycles during a dump -> beat stable for all 5 cycles; a tick during the dump is served immediately after dump_done.
REQ-036 Assert reset mid-dump -> wall_valid=0, score=0, no dump_done on the next cycle.
